// File: rtl/card_dispatch_arbiter.sv
// Card deck arbiter: grants the deck to player or dealer, runs the draw/return
// handshake and reshuffles near deck end. Optional redraw of invalid cards: CARD_REDRAW_EN.
module card_dispatch_arbiter #(
  parameter int CARD_W         = 4,
  parameter int DECK_LATENCY   = 1,
  parameter int DECK_SIZE      = 52,
  parameter int SHUFFLE_MARGIN = 10
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_playerReq,
  input  logic              i_dealerReq,
  output logic              o_playerGrant,
  output logic              o_dealerGrant,
  output logic [CARD_W-1:0] o_card,
  output logic              o_deckDraw,
  input  logic [CARD_W-1:0] i_deckCard,
  output logic              o_shuffleReq,
  input  logic              i_shuffleDone,
  output logic [5:0]        o_dealtCount,
  output logic              o_busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DRAW    = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_GRANT   = 3'd3;
  localparam logic [2:0] S_SHUFFLE = 3'd4;

  localparam logic       OWN_PLAYER = 1'b0;
  localparam logic       OWN_DEALER = 1'b1;

  localparam logic [6:0] SHUF_AT  = 7'(DECK_SIZE - SHUFFLE_MARGIN);
  localparam logic [2:0] LAT_LOAD = 3'(DECK_LATENCY - 1);

  logic [2:0]        state;
  logic              owner;
  logic              last_grant;
  logic [2:0]        lat_cnt;
  logic [CARD_W-1:0] card;
  logic [5:0]        dealt;
`ifdef CARD_REDRAW_EN
  logic [1:0]        bad_cnt;
`endif

  logic       need_shuffle;
  logic       any_req;
  logic       winner;
  logic [5:0] dealt_inc;

  assign need_shuffle = {1'b0, dealt} >= SHUF_AT;
  assign any_req      = i_playerReq | i_dealerReq;
  // On a tie the side that did not win last time takes the deck.
  assign winner       = (i_playerReq & i_dealerReq) ? ~last_grant : ~i_playerReq;
  assign dealt_inc    = (dealt == 6'd63) ? dealt : dealt + 6'd1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= S_IDLE;
      owner      <= OWN_PLAYER;
      last_grant <= OWN_DEALER;
      lat_cnt    <= '0;
      card       <= '0;
      dealt      <= '0;
`ifdef CARD_REDRAW_EN
      bad_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (need_shuffle) begin
            state <= S_SHUFFLE;
          end else if (any_req) begin
            owner <= winner;
            state <= S_DRAW;
          end
        end
        S_DRAW: begin
          lat_cnt <= LAT_LOAD;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt != 3'd0) begin
            lat_cnt <= lat_cnt - 3'd1;
          end else begin
`ifdef CARD_REDRAW_EN
            // A zero card is unusable: burn it and draw again, or give up and reshuffle.
            if (i_deckCard == '0) begin
              dealt <= dealt_inc;
              if (bad_cnt == 2'd2) begin
                bad_cnt <= '0;
                state   <= S_SHUFFLE;
              end else begin
                bad_cnt <= bad_cnt + 2'd1;
                state   <= S_DRAW;
              end
            end else begin
              card    <= i_deckCard;
              bad_cnt <= '0;
              state   <= S_GRANT;
            end
`else
            card  <= i_deckCard;
            state <= S_GRANT;
`endif
          end
        end
        S_GRANT: begin
          dealt      <= dealt_inc;
          last_grant <= owner;
          state      <= S_IDLE;
        end
        S_SHUFFLE: begin
          if (i_shuffleDone) begin
            dealt <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_playerGrant = (state == S_GRANT) && (owner == OWN_PLAYER);
  assign o_dealerGrant = (state == S_GRANT) && (owner == OWN_DEALER);
  assign o_deckDraw    = (state == S_DRAW);
  assign o_shuffleReq  = (state == S_SHUFFLE);
  assign o_busy        = (state != S_IDLE);
  assign o_card        = card;
  assign o_dealtCount  = dealt;

endmodule

// File: tb/tb_card_dispatch_arbiter.sv
// Scoreboard bench: instance a (latency 1) with a deck model, instance b (latency 3) driven per cycle.
module tb_card_dispatch_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_preq, a_dreq, a_pg, a_dg, a_draw, a_shreq, a_shdone, a_busy;
  logic [3:0] a_card, a_deck;
  logic [5:0] a_cnt;
  logic       b_rst_n, b_preq, b_dreq, b_pg, b_dg, b_draw, b_shreq, b_shdone, b_busy;
  logic [3:0] b_card, b_deck;
  logic [5:0] b_cnt;

  card_dispatch_arbiter #(.CARD_W(4), .DECK_LATENCY(1), .DECK_SIZE(52), .SHUFFLE_MARGIN(10)) u_a (
    .i_clk(clk), .i_reset_n(a_rst_n), .i_playerReq(a_preq), .i_dealerReq(a_dreq),
    .o_playerGrant(a_pg), .o_dealerGrant(a_dg), .o_card(a_card), .o_deckDraw(a_draw),
    .i_deckCard(a_deck), .o_shuffleReq(a_shreq), .i_shuffleDone(a_shdone),
    .o_dealtCount(a_cnt), .o_busy(a_busy));

  card_dispatch_arbiter #(.CARD_W(4), .DECK_LATENCY(3), .DECK_SIZE(52), .SHUFFLE_MARGIN(10)) u_b (
    .i_clk(clk), .i_reset_n(b_rst_n), .i_playerReq(b_preq), .i_dealerReq(b_dreq),
    .o_playerGrant(b_pg), .o_dealerGrant(b_dg), .o_card(b_card), .o_deckDraw(b_draw),
    .i_deckCard(b_deck), .o_shuffleReq(b_shreq), .i_shuffleDone(b_shdone),
    .o_dealtCount(b_cnt), .o_busy(b_busy));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Deck model for instance a: card presented only on the cycle it must be sampled.
  logic [3:0] a_deck_q[$];
  logic [4:0] exp_q[$];
  logic       a_pipe = 1'b0;
  logic [3:0] a_cur  = 4'd0;
  always @(posedge clk) begin
    a_pipe <= a_draw;
    if (a_draw) a_cur <= (a_deck_q.size() > 0) ? a_deck_q.pop_front() : 4'd5;
  end
  assign a_deck = a_pipe ? a_cur : 4'hE;

  int a_ngrant = 0;
  int a_ndraw  = 0;
  always @(negedge clk) begin
    if (a_pg || a_dg) begin
      a_ngrant++;
      chk("a_excl", {31'd0, a_pg & a_dg}, 32'd0);
      if (exp_q.size() == 0) chk("a_extra_grant", 32'd1, 32'd0);
      else chk("a_grant", {27'd0, a_dg, a_card}, {27'd0, exp_q.pop_front()});
    end
    if (a_draw) a_ndraw++;
    if (b_pg && b_dg) chk("b_excl", 32'd1, 32'd0);
  end

  task automatic wait_a_grant(input int lim);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(a_pg || a_dg) && n < lim);
    if (!(a_pg || a_dg)) chk("a_grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic reset_a();
    @(negedge clk); a_rst_n = 1'b0;
    @(negedge clk); a_rst_n = 1'b1;
  endtask

  task automatic serve_player(input logic [3:0] c);
    a_deck_q.push_back(c);
    exp_q.push_back({1'b0, c});
    a_preq = 1'b1;
    wait_a_grant(20);
    a_preq = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int d0, g0, n;
    a_rst_n = 0; a_preq = 0; a_dreq = 0; a_shdone = 0;
    b_rst_n = 0; b_preq = 0; b_dreq = 0; b_shdone = 0; b_deck = 4'hE;
    @(negedge clk);
    chk("rst_busy", {31'd0, a_busy}, 0);
    chk("rst_draw", {31'd0, a_draw}, 0);
    @(negedge clk); a_rst_n = 1; b_rst_n = 1;
    @(negedge clk);
    chk("rst_cnt",   {26'd0, a_cnt}, 0);
    chk("rst_card",  {28'd0, a_card}, 0);
    chk("rst_shreq", {31'd0, a_shreq}, 0);
    chk("rst_grant", {30'd0, a_pg, a_dg}, 0);

    // First transaction: draw at cycle 1, grant at cycle 3.
    a_preq = 1; a_deck_q.push_back(4'd7); exp_q.push_back({1'b0, 4'd7});
    @(negedge clk); chk("t1_draw", {31'd0, a_draw}, 1); chk("t1_busy", {31'd0, a_busy}, 1);
    @(negedge clk); chk("t1_nodraw", {31'd0, a_draw}, 0); chk("t1_early", {31'd0, a_pg}, 0);
    @(negedge clk); chk("t1_grant", {31'd0, a_pg}, 1); chk("t1_card", {28'd0, a_card}, 7);
    a_preq = 0;
    @(negedge clk); chk("t1_cnt", {26'd0, a_cnt}, 1); chk("t1_idle", {31'd0, a_busy}, 0);

    // Stray shuffle-done outside SHUFFLE does nothing.
    a_shdone = 1; @(negedge clk); a_shdone = 0; @(negedge clk);
    chk("stray_done_cnt", {26'd0, a_cnt}, 1);

    // Round robin from reset: P, D, P, D.
    reset_a();
    for (int i = 0; i < 4; i++) begin
      a_deck_q.push_back(4'(i + 1));
      exp_q.push_back({1'(i % 2), 4'(i + 1)});
    end
    a_preq = 1; a_dreq = 1;
    for (int i = 0; i < 4; i++) wait_a_grant(20);
    a_preq = 0; a_dreq = 0;
    @(negedge clk); chk("rr_cnt", {26'd0, a_cnt}, 4);

    // Fill to 41, then the 42nd grant, then the shuffle.
    for (int i = 0; i < 37; i++) serve_player(4'((i % 13) + 1));
    chk("pre_shuf_cnt", {26'd0, a_cnt}, 41);
    chk("pre_shuf_req", {31'd0, a_shreq}, 0);
    serve_player(4'd11);
    chk("cnt42", {26'd0, a_cnt}, 42);
    a_preq = 1; a_deck_q.push_back(4'd12); exp_q.push_back({1'b0, 4'd12});
    @(negedge clk); chk("shuf_req", {31'd0, a_shreq}, 1);
    d0 = a_ndraw;
    repeat (5) @(negedge clk);
    chk("shuf_nodraw", a_ndraw - d0, 0);
    chk("shuf_hold_cnt", {26'd0, a_cnt}, 42);
    a_shdone = 1; @(negedge clk); a_shdone = 0;
    chk("shuf_cnt0", {26'd0, a_cnt}, 0);
    chk("shuf_req_off", {31'd0, a_shreq}, 0);
    wait_a_grant(20);
    a_preq = 0;
    @(negedge clk); chk("post_shuf_cnt", {26'd0, a_cnt}, 1);

    // Instance b, latency 3: request dropped mid-transaction still granted.
    @(negedge clk); b_dreq = 1;
    @(negedge clk); chk("b_draw", {31'd0, b_draw}, 1);
    @(negedge clk); b_dreq = 0;
    @(negedge clk); chk("b_c3", {31'd0, b_dg}, 0);
    @(negedge clk); b_deck = 4'd9; chk("b_c4", {31'd0, b_dg}, 0);
    @(negedge clk); chk("b_grant", {31'd0, b_dg}, 1); chk("b_card", {28'd0, b_card}, 9);
    b_deck = 4'hE;
    @(negedge clk); chk("b_cnt1", {26'd0, b_cnt}, 1);

    // Reset during WAIT aborts the transaction.
    b_preq = 1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    b_rst_n = 0;
    #1;
    chk("abort_busy", {31'd0, b_busy}, 0);
    chk("abort_card", {28'd0, b_card}, 0);
    chk("abort_cnt",  {26'd0, b_cnt}, 0);
    b_preq = 0;
    @(negedge clk); b_rst_n = 1;
    n = 0;
    repeat (6) begin @(negedge clk); if (b_pg || b_dg) n++; end
    chk("abort_nogrant", n, 0);

`ifdef CARD_REDRAW_EN
    reset_a();
    d0 = a_ndraw;
    a_deck_q.push_back(4'd0); a_deck_q.push_back(4'd0); a_deck_q.push_back(4'd9);
    exp_q.push_back({1'b0, 4'd9});
    a_preq = 1;
    wait_a_grant(30);
    a_preq = 0;
    chk("rd_draws", a_ndraw - d0, 3);
    @(negedge clk); chk("rd_cnt", {26'd0, a_cnt}, 3);
    reset_a();
    d0 = a_ndraw; g0 = a_ngrant;
    a_deck_q.push_back(4'd0); a_deck_q.push_back(4'd0); a_deck_q.push_back(4'd0);
    a_preq = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!a_shreq && n < 30);
    chk("rd_shuf", {31'd0, a_shreq}, 1);
    chk("rd_shuf_draws", a_ndraw - d0, 3);
    chk("rd_shuf_nogrant", a_ngrant - g0, 0);
    chk("rd_shuf_cnt", {26'd0, a_cnt}, 3);
    a_preq = 0;
    a_shdone = 1; @(negedge clk); a_shdone = 0; @(negedge clk);
`else
    // Without redraw, a zero card is delivered as-is.
    serve_player(4'd0);
    chk("zero_card_cnt", {26'd0, a_cnt}, 2);
`endif

    repeat (3) @(negedge clk);
    chk("exp_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/card_dispatch_arbiter.md
Name: card_dispatch_arbiter

Overview:
- Sits between the card deck and the two hand controllers (player, dealer).
- Grants the single deck to one requester at a time, sequences the draw/return handshake, and delivers exactly one card per grant.
- Counts cards dealt since the last shuffle and holds off grants while the deck reshuffles.

Parameters:
- CARD_W, 4, width of a card value (matches `card).
- DECK_LATENCY, 1, cycles from o_deckDraw to i_deckCard valid (1..7).
- DECK_SIZE, 52, cards per deck.
- SHUFFLE_MARGIN, 10, reshuffle once cards dealt >= DECK_SIZE - SHUFFLE_MARGIN.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_playerReq  in  1  player hand wants a card (level, held until grant).
- i_dealerReq  in  1  dealer hand wants a card (level, held until grant).
- o_playerGrant  out  1  one-cycle pulse: o_card valid for player.
- o_dealerGrant  out  1  one-cycle pulse: o_card valid for dealer.
- o_card  out  CARD_W  delivered card; held stable until the next grant.
- o_deckDraw  out  1  one-cycle pulse requesting a card from the deck.
- i_deckCard  in  CARD_W  deck output, sampled DECK_LATENCY cycles after o_deckDraw.
- o_shuffleReq  out  1  level: deck must reshuffle.
- i_shuffleDone  in  1  one-cycle pulse: reshuffle complete.
- o_dealtCount  out  6  cards dealt since last shuffle.
- o_busy  out  1  high in any state but IDLE.

Behaviour:
- Reset (async, i_reset_n low): state IDLE; all grants, o_deckDraw, o_shuffleReq, o_busy = 0; o_card = 0; o_dealtCount = 0; lastGrant = DEALER (so the player wins the first tie).
- States: IDLE, DRAW, WAIT, GRANT, SHUFFLE.
- IDLE:
  - If o_dealtCount >= DECK_SIZE-SHUFFLE_MARGIN, go to SHUFFLE. This takes priority over pending requests.
  - Else if any request is high, latch the winner in owner and go to DRAW.
  - Arbitration: a single requester wins. If both are high, round-robin against lastGrant.
- DRAW: o_deckDraw = 1 for exactly one cycle, load the latency counter with DECK_LATENCY-1, go to WAIT.
- WAIT:
  - Count down. At 0, register i_deckCard into o_card and go to GRANT.
  - DECK_LATENCY=1 means the card is sampled on the cycle after the draw pulse.
- GRANT:
  - Pulse the grant for owner for one cycle.
  - o_dealtCount += 1, saturating at 63.
  - lastGrant = owner; go to IDLE.
  - Minimum request-to-grant latency = DECK_LATENCY + 2 cycles.
- Requests are not re-sampled between DRAW and GRANT. If the owner drops its request mid-transaction, the card is still granted (no cancel).
- A requester must drop its request the cycle after its grant. A request still high in IDLE counts as a new request.
- SHUFFLE:
  - o_shuffleReq = 1. No grants and no draws.
  - On i_shuffleDone: o_dealtCount = 0, o_shuffleReq = 0, go to IDLE.
  - i_shuffleDone outside SHUFFLE is ignored.
- Grants are mutually exclusive. At most one draw is outstanding.
- Reset asserted mid-transaction aborts immediately. The in-flight card is discarded and no grant is issued.

Optional Feature:
- Macro: CARD_REDRAW_EN.
- Defined:
  - In WAIT, if the sampled i_deckCard == 0 (invalid card), do not grant. Return to DRAW and issue another o_deckDraw.
  - Redraws also increment o_dealtCount.
  - After 3 consecutive invalid draws, force SHUFFLE (grant still pending; owner re-arbitrated after shuffle).
- Undefined: i_deckCard is granted unconditionally, including 0.

Test Plan:
- Reset then i_playerReq=1, DECK_LATENCY=1, i_deckCard=4'd7 -> o_deckDraw pulse at cycle 1, o_playerGrant pulse at cycle 3 with o_card=7, o_dealtCount=1.
- i_playerReq and i_dealerReq both held high for 4 transactions -> grant order player, dealer, player, dealer; grants never overlap.
- Preload o_dealtCount to 41 (41 grants), then request -> 42nd grant issued, next request produces o_shuffleReq=1 and no o_deckDraw until i_shuffleDone. Count then reads 0 and the pending request is served.
- DECK_LATENCY=3, i_dealerReq dropped the cycle after o_deckDraw -> o_dealerGrant still pulses 5 cycles after the request, with the card sampled 3 cycles after the draw.
- i_reset_n low during WAIT -> no grant, o_card=0, state IDLE, count unchanged from reset (0).
- CARD_REDRAW_EN: deck returns 0, 0, 9 -> three o_deckDraw pulses, single grant with o_card=9, o_dealtCount=3. Deck returns 0, 0, 0 -> o_shuffleReq asserted, no grant.
